wb_b3_burst_reader: RTL

Wishbone B3 read-burst master that sits directly upstream of the on-chip RAM slave. It turns a simple command (start byte address, word count) into a registered-feedback incrementing burst and buffers the returned words in a local FIFO for a streaming consumer. A burst is launched only when the whole burst fits in the FIFO, so STB never drops mid-burst. Address errors reported by the slave abort the command cleanly.

---
 rtl/rdr_pkg.sv | 29 ++
 rtl/wb_rd_fifo.sv | 55 +++++
 rtl/wb_b3_burst_reader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rdr_pkg.sv
// Shared constants and state type for the Wishbone B3 burst reader.
package rdr_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    BURST
  } rdr_state_e;

  // Byte-offset mask of the wrap window; zero means linear increment.
  function automatic logic [5:0] wrap_mask(input logic [1:0] bte);
    case (bte)
      BTE_WRAP4:  wrap_mask = 6'h0f;
      BTE_WRAP8:  wrap_mask = 6'h1f;
      BTE_WRAP16: wrap_mask = 6'h3f;
      default:    wrap_mask = 6'h00;
    endcase
  endfunction

endpackage

// File: rtl/wb_rd_fifo.sv
// Synchronous read-data FIFO with same-cycle push/pop and a free-word count.
module wb_rd_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic [CW-1:0] free_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;

  assign pop        = pop_i && (count_q != '0);
  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign free_o     = CW'(DEPTH) - count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_i) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // The reader only launches bursts that fit, so a push into a full FIFO is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/wb_b3_burst_reader.sv
// Wishbone B3 incrementing-burst read master feeding a local FIFO.
// Define RDR_WRAP_BURST_EN to enable wrap bursts driven by cmd_bte_i.
module wb_b3_burst_reader
  import rdr_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [4:0]    cmd_len_i,
  input  logic [1:0]    cmd_bte_i,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [DW-1:0] rd_data_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rdr_state_e    state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [4:0]    rem_q, rem_d;
  logic [1:0]    bte_q, bte_d;
  logic [2:0]    cti_q, cti_d;
  logic          cyc_q, cyc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [1:0]    bte_cmd;
  logic [CW-1:0] free_w;
  logic [CW:0]   space_w;
  logic          push_w;
  logic          pop_w;
  logic          unused_ok;

`ifdef RDR_WRAP_BURST_EN
  assign bte_cmd = cmd_bte_i;
`else
  assign bte_cmd = BTE_LINEAR;
`endif

  assign unused_ok = ^{cmd_adr_i[1:0], cmd_bte_i, wb_rty_i};

  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
    logic [5:0] m;
    logic [5:0] lo;
    m  = wrap_mask(bte);
    lo = a[5:0] + 6'd4;
    if (m == 6'd0) next_adr = a + AW'(4);
    else           next_adr = {a[AW-1:6], (a[5:0] & ~m) | (lo & m)};
  endfunction

  assign pop_w  = rd_valid_o && rd_ready_i;
  assign push_w = (state_q == BURST) && wb_ack_i && !wb_err_i;
  // A pop taken this edge frees its slot before any beat of the new burst can land.
  assign space_w = {1'b0, free_w} + {{CW{1'b0}}, pop_w};

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    bte_d   = bte_q;
    cti_d   = cti_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          adr_d = {cmd_adr_i[AW-1:2], 2'b00};
          rem_d = cmd_len_i;
          bte_d = bte_cmd;
          if (cmd_len_i == 5'd0) begin
            done_d = 1'b1;
          end else if (space_w >= {{(CW-4){1'b0}}, cmd_len_i}) begin
            cyc_d   = 1'b1;
            cti_d   = (cmd_len_i == 5'd1) ? CTI_CLASSIC : CTI_INCR;
            state_d = BURST;
          end else begin
            state_d = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        if (space_w >= {{(CW-4){1'b0}}, rem_q}) begin
          cyc_d   = 1'b1;
          cti_d   = (rem_q == 5'd1) ? CTI_CLASSIC : CTI_INCR;
          state_d = BURST;
        end
      end
      BURST: begin
        if (wb_err_i) begin
          cyc_d   = 1'b0;
          cti_d   = CTI_CLASSIC;
          rem_d   = 5'd0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (wb_ack_i) begin
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            cyc_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            adr_d = next_adr(adr_q, bte_q);
            cti_d = (rem_q == 5'd2) ? CTI_EOB : CTI_INCR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      bte_q   <= BTE_LINEAR;
      cti_q   <= CTI_CLASSIC;
      cyc_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      bte_q   <= bte_d;
      cti_q   <= cti_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  wb_rd_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_n_i),
    .push_i      (push_w),
    .push_data_i (wb_dat_i),
    .pop_i       (rd_ready_i),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .free_o      (free_w)
  );

  assign cmd_ready_o = (state_q == IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign wb_adr_o    = adr_q;
  assign wb_cti_o    = cti_q;
  assign wb_bte_o    = bte_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = 1'b0;
  assign wb_sel_o    = 4'hf;

endmodule
